// File: rtl/spi_pkg.sv
// Shared types and width helpers for the configurable SPI master.
//   spi_state_t : transfer FSM states
//   spi_mode_t  : clock polarity / phase pair captured with each transfer
//   sel_w       : width of the slave-select index (never less than 1)
//   edge_cnt_w  : width of the SCLK edge counter, $clog2(DATA_W)+1
//   div_cnt_w   : width of the half-period divider counter (never less than 1)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned edge_cnt_w(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

  function automatic int unsigned div_cnt_w(input int unsigned clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for the SPI master.
// Counts CLK_DIV system clocks while enabled and pulses tick_c on the last one.
// The counter is held at zero whenever en is low, so every transfer starts
// from a fresh half-period.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   en      : count enable (high during SETUP/XFER/HOLD)
//   tick_c  : combinational one-cycle tick at the end of each half-period
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = div_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running modulo-CLK_DIV counter, cleared while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_c = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master.
// Shifts DATA_W bits out on mosi while capturing DATA_W bits from miso, in any
// of the four CPOL/CPHA modes, with NUM_SS active-low slave selects.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input; without it
// every transfer is MSB first.
//   clk, reset_n : system clock, asynchronous active-low reset
//   start        : transfer request, honoured only in IDLE
//   cpol, cpha   : SPI mode for the next transfer
//   ss_sel       : slave index for the next transfer
//   din / dout   : transmit word / last received word (updated with done)
//   lsb_first    : (SPI_LSB_FIRST_EN only) bit order for the next transfer
//   busy, done   : transfer in progress / one-cycle completion pulse
//   sclk, mosi, miso, ss_n : SPI pins
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_SS  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [sel_w(NUM_SS)-1:0]  ss_sel,
  input  logic [DATA_W-1:0]         din,
`ifdef SPI_LSB_FIRST_EN
  input  logic                      lsb_first,
`endif
  output logic [DATA_W-1:0]         dout,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_SS-1:0]         ss_n
);

  localparam int unsigned SEL_W = sel_w(NUM_SS);
  localparam int unsigned CNT_W = edge_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

  spi_state_t state_q, state_d;

  spi_mode_t           mode_q;
  logic [SEL_W-1:0]    sel_q;
  logic                lsb_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic [CNT_W-1:0]    edge_cnt_q;

  logic                tick_c;
  logic                clk_en_c;
  logic                accept_c;
  logic                lsb_in_c;
  logic                xfer_tick_c;
  logic                lead_c;
  logic                trail_c;
  logic                last_edge_c;
  logic                drive_c;
  logic                sample_c;

  logic                busy_d;
  logic                done_d;
  logic                sclk_d;
  logic                mosi_d;
  logic [NUM_SS-1:0]   ss_n_d;
  logic [DATA_W-1:0]   dout_d;
  logic [SEL_W-1:0]    sel_src;

  // Bit-order helpers
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] w,
                                                   input logic b,
                                                   input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_c = lsb_first;
`else
  assign lsb_in_c = 1'b0;
`endif

  assign clk_en_c = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clk_en_c),
    .tick_c  (tick_c)
  );

  // Edge classification: even edge indices are leading, odd ones trailing
  assign accept_c    = (state_q == IDLE) && start;
  assign xfer_tick_c = tick_c && (state_q == XFER);
  assign lead_c      = xfer_tick_c && !edge_cnt_q[0];
  assign trail_c     = xfer_tick_c && edge_cnt_q[0];
  assign last_edge_c = (edge_cnt_q == LAST_EDGE);
  // The final trailing edge in CPHA=0 does not shift, so mosi holds the last bit
  assign drive_c     = mode_q.cpha ? lead_c : (trail_c && !last_edge_c);
  assign sample_c    = mode_q.cpha ? trail_c : lead_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                     state_d = SETUP;
      SETUP:   if (tick_c)                    state_d = XFER;
      XFER:    if (tick_c && last_edge_c)     state_d = HOLD;
      HOLD:    if (tick_c)                    state_d = DONE;
      DONE:                                   state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered pins, keyed to the next state
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ss_n_d  = '1;
    sclk_d  = sclk;
    mosi_d  = mosi;
    dout_d  = dout;
    // On the accepting edge the latched select is not yet valid
    sel_src = (state_q == IDLE) ? ss_sel : sel_q;

    busy_d = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
    done_d = (state_d == DONE);
    if (done_d) begin
      dout_d = rx_q;
    end

    // Out-of-range indices match no line, so nothing is selected
    for (int i = 0; i < int'(NUM_SS); i++) begin
      if (busy_d && (sel_src == SEL_W'(i))) begin
        ss_n_d[i] = 1'b0;
      end
    end

    case (state_q)
      IDLE:    sclk_d = cpol;
      XFER:    if (tick_c) sclk_d = ~sclk;
      default: sclk_d = mode_q.cpol;
    endcase

    if (accept_c && !cpha) begin
      mosi_d = first_bit(din, lsb_in_c);
    end else if (drive_c) begin
      mosi_d = first_bit(tx_q, lsb_q);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      ss_n <= '1;
      dout <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      sclk <= sclk_d;
      mosi <= mosi_d;
      ss_n <= ss_n_d;
      dout <= dout_d;
    end
  end

  // Transfer context, shift registers and edge counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= '0;
      sel_q      <= '0;
      lsb_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      edge_cnt_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        mode_q.cpol <= cpol;
      end
      if (accept_c) begin
        mode_q.cpha <= cpha;
        sel_q       <= ss_sel;
        lsb_q       <= lsb_in_c;
        edge_cnt_q  <= '0;
        // CPHA=0 already presents the first bit, so drop it from the queue
        tx_q        <= cpha ? din : shift_word(din, lsb_in_c);
      end
      if (drive_c) begin
        tx_q <= shift_word(tx_q, lsb_q);
      end
      if (sample_c) begin
        rx_q <= insert_bit(rx_q, miso, lsb_q);
      end
      if (xfer_tick_c && !last_edge_c) begin
        edge_cnt_q <= edge_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
